// File: rtl/ip_codma_bus_responder_if.sv
// Bus between the codma master and the memory-backed responder.
interface ip_codma_bus_responder_if #(
  parameter int WQ_DEPTH = 4
) ();
  logic [3:0]                   size_i;
  logic [31:0]                  addr_i;
  logic                         read_i;
  logic                         write_i;
  logic                         grant_o;
  logic [255:0]                 write_data_i;
  logic                         write_valid_i;
  logic [255:0]                 read_data_o;
  logic                         read_valid_o;
  logic                         error_o;
  logic [$clog2(WQ_DEPTH):0]    wq_count_o;

  modport master (
    output size_i, addr_i, read_i, write_i, write_data_i, write_valid_i,
    input  grant_o, read_data_o, read_valid_o, error_o, wq_count_o
  );

  modport slave (
    input  size_i, addr_i, read_i, write_i, write_data_i, write_valid_i,
    output grant_o, read_data_o, read_valid_o, error_o, wq_count_o
  );
endinterface

// File: rtl/ip_codma_bus_responder.sv
// Memory-backed slave for the codma bus: fixed-latency reads, write requests
// queued in order and paired with later write-data beats.
module ip_codma_bus_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2,
  parameter int WQ_DEPTH  = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  ip_codma_bus_responder_if.slave bus
);
  localparam int IDXW = $clog2(MEM_WORDS);
  localparam int PTRW = $clog2(WQ_DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam logic [32:0]     MEM_LIMIT = 33'(MEM_WORDS);
  localparam logic [CNTW-1:0] WQ_FULL   = CNTW'(WQ_DEPTH);

  logic [31:0]        mem_r     [MEM_WORDS];
  logic [IDXW-1:0]    q_idx_r   [WQ_DEPTH];
  logic [3:0]         q_words_r [WQ_DEPTH];
  logic               q_bad_r   [WQ_DEPTH];
  logic [PTRW-1:0]    q_head_r;
  logic [PTRW-1:0]    q_tail_r;
  logic [CNTW-1:0]    q_count_r;
  logic [LATENCY-1:0] rd_valid_r;
  logic [255:0]       rd_data_r [LATENCY];
  logic               error_r;

  logic [3:0]      words_s;
  logic [32:0]     first_s;
  logic [32:0]     last_s;
  logic            size_ok_s;
  logic            aligned_s;
  logic            in_range_s;
  logic            bad_req_s;
  logic [IDXW-1:0] req_idx_s;
  logic            both_s;
  logic            rd_grant_s;
  logic            wr_grant_s;
  logic            beat_s;
  logic            pop_s;
  logic            bypass_s;
  logic            push_s;
  logic            orphan_s;
  logic            err_s;
  logic [IDXW-1:0] c_idx_s;
  logic [3:0]      c_words_s;
  logic            c_bad_s;
  logic            commit_s;
  logic [255:0]    rd_sample_s;

  // Request legality: size, word/transfer alignment and memory range.
  always_comb begin
    size_ok_s = (bus.size_i <= 4'd3);
    case (bus.size_i)
      4'd0:    words_s = 4'd1;
      4'd1:    words_s = 4'd2;
      4'd2:    words_s = 4'd4;
      4'd3:    words_s = 4'd8;
      default: words_s = 4'd1;
    endcase
    first_s    = {3'b000, bus.addr_i[31:2]};
    last_s     = first_s + {29'd0, words_s} - 33'd1;
    aligned_s  = (bus.addr_i[1:0] == 2'b00) &&
                 ((bus.addr_i[31:2] & {26'd0, words_s - 4'd1}) == 30'd0);
    in_range_s = (last_s < MEM_LIMIT);
    bad_req_s  = !(size_ok_s && aligned_s && in_range_s);
    req_idx_s  = bus.addr_i[IDXW+1:2];
  end

  // Grants, queue push/pop/bypass decisions and the commit source.
  always_comb begin
    both_s     = bus.read_i && bus.write_i && !reset_i;
    rd_grant_s = bus.read_i && !bus.write_i && !reset_i;
    wr_grant_s = bus.write_i && !bus.read_i && (q_count_r < WQ_FULL) && !reset_i;
    beat_s     = bus.write_valid_i && !reset_i;
    pop_s      = beat_s && (q_count_r != {CNTW{1'b0}});
    bypass_s   = beat_s && (q_count_r == {CNTW{1'b0}}) && wr_grant_s;
    push_s     = wr_grant_s && !bypass_s;
    orphan_s   = beat_s && (q_count_r == {CNTW{1'b0}}) && !wr_grant_s;
    err_s      = both_s || ((rd_grant_s || wr_grant_s) && bad_req_s) || orphan_s;
    if (pop_s) begin
      c_idx_s   = q_idx_r[q_head_r];
      c_words_s = q_words_r[q_head_r];
      c_bad_s   = q_bad_r[q_head_r];
    end else begin
      c_idx_s   = req_idx_s;
      c_words_s = words_s;
      c_bad_s   = bad_req_s;
    end
    commit_s = (pop_s || bypass_s) && !c_bad_s;
  end

  // Read lanes sampled from memory before any same-edge commit lands.
  always_comb begin
    rd_sample_s = {256{1'b0}};
    for (int k = 0; k < 8; k++) begin
      if (!bad_req_s && (4'(k) < words_s)) begin
        rd_sample_s[32*k +: 32] = mem_r[req_idx_s + IDXW'(k)];
      end else begin
        rd_sample_s[32*k +: 32] = 32'd0;
      end
    end
  end

  assign bus.grant_o = rd_grant_s || wr_grant_s;

  // Queue pointers, count and error pulse.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q_head_r  <= {PTRW{1'b0}};
      q_tail_r  <= {PTRW{1'b0}};
      q_count_r <= {CNTW{1'b0}};
      error_r   <= 1'b0;
    end else begin
      if (push_s) begin
        q_tail_r <= q_tail_r + {{(PTRW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        q_head_r <= q_head_r + {{(PTRW-1){1'b0}}, 1'b1};
      end
      q_count_r <= q_count_r + {{PTRW{1'b0}}, push_s} - {{PTRW{1'b0}}, pop_s};
      error_r   <= err_s;
    end
  end

  // Queue entry storage; contents are meaningless once the pointers reset.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      q_idx_r[q_tail_r]   <= req_idx_s;
      q_words_r[q_tail_r] <= words_s;
      q_bad_r[q_tail_r]   <= bad_req_s;
    end
  end

  // Fixed-latency read pipeline; data is zero on idle stages.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_valid_r <= {LATENCY{1'b0}};
      for (int i = 0; i < LATENCY; i++) begin
        rd_data_r[i] <= {256{1'b0}};
      end
    end else begin
      rd_valid_r[0] <= rd_grant_s;
      rd_data_r[0]  <= rd_grant_s ? rd_sample_s : {256{1'b0}};
      for (int i = 1; i < LATENCY; i++) begin
        rd_valid_r[i] <= rd_valid_r[i-1];
        rd_data_r[i]  <= rd_data_r[i-1];
      end
    end
  end

  // Memory array, deliberately untouched by reset.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 8; k++) begin
      if (commit_s && (4'(k) < c_words_s)) begin
        mem_r[c_idx_s + IDXW'(k)] <= bus.write_data_i[32*k +: 32];
      end
    end
  end

  assign bus.read_valid_o = rd_valid_r[LATENCY-1];
  assign bus.read_data_o  = rd_data_r[LATENCY-1];
  assign bus.error_o      = error_r;
  assign bus.wq_count_o   = q_count_r;
endmodule

// File: tb/tb_ip_codma_bus_responder.sv
// Directed bench for ip_codma_bus_responder; read data is checked by a scoreboard monitor.
module tb_ip_codma_bus_responder;
  localparam int LAT = 2;

  logic clk_i;
  logic reset_i;
  ip_codma_bus_responder_if #(.WQ_DEPTH(4)) bus ();

  ip_codma_bus_responder #(.MEM_WORDS(1024), .LATENCY(LAT), .WQ_DEPTH(4)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  typedef struct {
    logic [255:0] data;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_cnt = 0;
  int   err_seen = 0;
  int   exp_err = 0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  // Monitor: counts error pulses and checks every read response against the scoreboard.
  always @(negedge clk_i) begin
    exp_t e;
    if (bus.error_o === 1'b1) err_seen = err_seen + 1;
    if (bus.read_valid_o === 1'b1) begin
      n_cmp = n_cmp + 1;
      if (sb.size() == 0) begin
        n_bad = n_bad + 1;
        $display("FAIL unexpected_read_valid: got data=%h at cycle %0d, want no response", bus.read_data_o, cyc_cnt);
      end else begin
        e = sb.pop_front();
        if (bus.read_data_o !== e.data || cyc_cnt != e.due) begin
          n_bad = n_bad + 1;
          $display("FAIL read_data: got %h at cycle %0d, want %h at cycle %0d", bus.read_data_o, cyc_cnt, e.data, e.due);
        end
      end
    end else begin
      n_cmp = n_cmp + 1;
      if (bus.read_data_o !== 256'd0) begin
        n_bad = n_bad + 1;
        $display("FAIL idle_data_zero: got %h, want 0", bus.read_data_o);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp = n_cmp + 1;
    if (got !== want) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Read request; reads are never back-pressured, so grant is checked at once.
  task automatic do_read(input logic [3:0] sz, input logic [31:0] a, input logic [255:0] exp_d, input bit expect_rsp);
    exp_t e;
    bus.read_i = 1'b1;
    bus.size_i = sz;
    bus.addr_i = a;
    @(negedge clk_i);
    chk("read_grant", {63'd0, bus.grant_o}, 64'd1);
    if (expect_rsp) begin
      e.data = exp_d;
      e.due  = cyc_cnt + LAT;
      sb.push_back(e);
    end
    cyc();
    bus.read_i = 1'b0;
  endtask

  // Write request held until granted, bounded.
  task automatic write_req(input logic [3:0] sz, input logic [31:0] a);
    bit got;
    got = 1'b0;
    bus.write_i = 1'b1;
    bus.size_i  = sz;
    bus.addr_i  = a;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk_i);
      if (bus.grant_o === 1'b1) got = 1'b1;
      cyc();
    end
    n_cmp = n_cmp + 1;
    if (!got) begin
      n_bad = n_bad + 1;
      $display("FAIL write_grant_timeout: got no grant for addr %h, want grant within 16 cycles", a);
    end
    bus.write_i = 1'b0;
  endtask

  task automatic beat(input logic [255:0] d);
    bus.write_valid_i = 1'b1;
    bus.write_data_i  = d;
    cyc();
    bus.write_valid_i = 1'b0;
  endtask

  logic [255:0] blk8;
  logic [255:0] blk2;

  initial begin
    for (int k = 0; k < 8; k++) blk8[32*k +: 32] = 32'h11 * (k + 1);
    blk2 = {192'd0, 32'h22, 32'h11};

    bus.size_i = 4'd0;
    bus.addr_i = 32'd0;
    bus.read_i = 1'b0;
    bus.write_i = 1'b0;
    bus.write_data_i = 256'd0;
    bus.write_valid_i = 1'b0;

    // Reset: grant forced low even with a request present.
    reset_i = 1'b1;
    bus.read_i = 1'b1;
    idle(3);
    @(negedge clk_i);
    chk("reset_grant", {63'd0, bus.grant_o}, 64'd0);
    chk("reset_valid", {63'd0, bus.read_valid_o}, 64'd0);
    chk("reset_error", {63'd0, bus.error_o}, 64'd0);
    chk("reset_count", {61'd0, bus.wq_count_o}, 64'd0);
    cyc();
    bus.read_i = 1'b0;
    reset_i = 1'b0;
    idle(2);

    // 8-word write through the queue, then read back.
    write_req(4'd3, 32'h40);
    @(negedge clk_i);
    chk("count_after_req", {61'd0, bus.wq_count_o}, 64'd1);
    cyc();
    beat(blk8);
    @(negedge clk_i);
    chk("count_after_beat", {61'd0, bus.wq_count_o}, 64'd0);
    cyc();
    do_read(4'd3, 32'h40, blk8, 1'b1);
    idle(4);
    chk("err_none", 64'(err_seen), 64'(exp_err));

    // Fill the queue, check backpressure and in-order commit.
    write_req(4'd0, 32'h200);
    write_req(4'd0, 32'h204);
    write_req(4'd0, 32'h208);
    write_req(4'd0, 32'h20C);
    @(negedge clk_i);
    chk("count_full", {61'd0, bus.wq_count_o}, 64'd4);
    cyc();
    bus.write_i = 1'b1;
    bus.size_i = 4'd0;
    bus.addr_i = 32'h210;
    bus.write_valid_i = 1'b1;
    bus.write_data_i = {224'd0, 32'hA0};
    @(negedge clk_i);
    chk("full_grant", {63'd0, bus.grant_o}, 64'd0);
    cyc();
    bus.write_valid_i = 1'b0;
    @(negedge clk_i);
    chk("count_after_pop", {61'd0, bus.wq_count_o}, 64'd3);
    chk("fifth_grant", {63'd0, bus.grant_o}, 64'd1);
    cyc();
    bus.write_i = 1'b0;
    @(negedge clk_i);
    chk("count_refill", {61'd0, bus.wq_count_o}, 64'd4);
    cyc();
    beat({224'd0, 32'hA1});
    beat({224'd0, 32'hA2});
    beat({224'd0, 32'hA3});
    beat({224'd0, 32'hA4});
    @(negedge clk_i);
    chk("count_drained", {61'd0, bus.wq_count_o}, 64'd0);
    cyc();
    do_read(4'd0, 32'h200, {224'd0, 32'hA0}, 1'b1);
    do_read(4'd0, 32'h204, {224'd0, 32'hA1}, 1'b1);
    do_read(4'd0, 32'h208, {224'd0, 32'hA2}, 1'b1);
    do_read(4'd0, 32'h20C, {224'd0, 32'hA3}, 1'b1);
    do_read(4'd0, 32'h210, {224'd0, 32'hA4}, 1'b1);
    idle(4);

    // Flagged reads: misaligned and just past the end of memory.
    do_read(4'd1, 32'h4, 256'd0, 1'b1);
    exp_err = exp_err + 1;
    idle(4);
    chk("err_misaligned", 64'(err_seen), 64'(exp_err));
    do_read(4'd0, 32'h1000, 256'd0, 1'b1);
    exp_err = exp_err + 1;
    idle(4);
    chk("err_range", 64'(err_seen), 64'(exp_err));

    // Illegal-size write is queued, flagged and its beat discarded.
    write_req(4'd5, 32'h40);
    exp_err = exp_err + 1;
    beat({256{1'b1}});
    idle(2);
    chk("err_bad_size", 64'(err_seen), 64'(exp_err));
    chk("count_bad_write", {61'd0, bus.wq_count_o}, 64'd0);
    do_read(4'd3, 32'h40, blk8, 1'b1);
    idle(4);

    // read_i and write_i together: no grant, one error, count unchanged.
    bus.read_i = 1'b1;
    bus.write_i = 1'b1;
    bus.size_i = 4'd0;
    bus.addr_i = 32'h40;
    @(negedge clk_i);
    chk("both_grant", {63'd0, bus.grant_o}, 64'd0);
    cyc();
    bus.read_i = 1'b0;
    bus.write_i = 1'b0;
    exp_err = exp_err + 1;
    idle(3);
    chk("err_both", 64'(err_seen), 64'(exp_err));
    chk("count_both", {61'd0, bus.wq_count_o}, 64'd0);

    // Orphan data beat: error, memory unchanged.
    beat({224'd0, 32'h5555AAAA});
    exp_err = exp_err + 1;
    idle(3);
    chk("err_orphan", 64'(err_seen), 64'(exp_err));
    do_read(4'd0, 32'h40, {224'd0, 32'h11}, 1'b1);
    idle(4);

    // Reset one cycle after a read grant with two queued writes.
    write_req(4'd0, 32'h40);
    write_req(4'd0, 32'h44);
    @(negedge clk_i);
    chk("count_pre_reset", {61'd0, bus.wq_count_o}, 64'd2);
    cyc();
    do_read(4'd0, 32'h40, 256'd0, 1'b0);
    reset_i = 1'b1;
    idle(2);
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("count_post_reset", {61'd0, bus.wq_count_o}, 64'd0);
    cyc();
    idle(4);
    do_read(4'd1, 32'h40, blk2, 1'b1);
    idle(4);

    // Bypass: empty queue, request and beat in the same cycle.
    bus.write_i = 1'b1;
    bus.size_i = 4'd0;
    bus.addr_i = 32'h100;
    bus.write_valid_i = 1'b1;
    bus.write_data_i = {224'd0, 32'hDEADBEEF};
    @(negedge clk_i);
    chk("bypass_grant", {63'd0, bus.grant_o}, 64'd1);
    cyc();
    bus.write_i = 1'b0;
    bus.write_valid_i = 1'b0;
    @(negedge clk_i);
    chk("bypass_count", {61'd0, bus.wq_count_o}, 64'd0);
    cyc();
    do_read(4'd0, 32'h100, {224'd0, 32'hDEADBEEF}, 1'b1);

    // Read granted on the commit edge sees old data; the next read sees new.
    write_req(4'd0, 32'h100);
    bus.write_valid_i = 1'b1;
    bus.write_data_i = {224'd0, 32'hCAFEF00D};
    do_read(4'd0, 32'h100, {224'd0, 32'hDEADBEEF}, 1'b1);
    bus.write_valid_i = 1'b0;
    do_read(4'd0, 32'h100, {224'd0, 32'hCAFEF00D}, 1'b1);
    idle(6);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    chk("err_total", 64'(err_seen), 64'(exp_err));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at %0t, want bench completion", $time);
    $fatal(1);
  end
endmodule
